// File: rtl/vec_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vec_lsu_pkg
// Purpose  : Shared definitions for the vector strided load/store engine.
//            Holds the SEW encodings, the FSM state encoding and the byte-lane
//            mask helper.
// Revision : 1.0 - initial release
// ============================================================================
package vec_lsu_pkg;

   // Element width encodings as delivered by the vector decode logic
   localparam logic [1:0] SEW_E8  = 2'b00;
   localparam logic [1:0] SEW_E16 = 2'b01;
   localparam logic [1:0] SEW_E32 = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      FIN   = 2'd2
   } state_e;

   // Byte-lane mask of one element inside a 32-bit word.
   // The reserved encoding 2'b11 falls into the full-word case.
   function automatic logic [3:0] lane_mask(input logic [1:0] sew,
                                            input logic [1:0] off);
      logic [3:0] m;
      case (sew)
         SEW_E8:  m = 4'b0001 << off;
         SEW_E16: m = 4'b0011 << off;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vec_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : vec_lane_align
// Purpose  : Combinational byte-lane steering for one vector element.
//            Produces store strobes and shifted store data, extracts and
//            zero-extends a loaded element, and flags misaligned offsets.
//            Misaligned offset bits are cleared before steering; the top
//            decides whether a misaligned element is trapped instead
//            (VEC_LSU_MISALIGN_TRAP_EN).
// Revision : 1.0 - initial release
// ============================================================================
module vec_lane_align
   import vec_lsu_pkg::*;
(
   input  logic [1:0]  sew_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] sdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] relem_o,
   output logic        misalign_o
);

   logic [1:0]  w_off;
   logic [4:0]  w_shift;
   logic [31:0] w_rsh;

   // Align the offset to the element size, then steer store and load lanes
   always_comb begin
      w_off      = 2'b00;
      misalign_o = 1'b0;
      case (sew_i)
         SEW_E8: begin
            w_off = off_i;
         end
         SEW_E16: begin
            w_off      = {off_i[1], 1'b0};
            misalign_o = off_i[0];
         end
         default: begin
            w_off      = 2'b00;
            misalign_o = (off_i != 2'b00);
         end
      endcase

      w_shift = {w_off, 3'b000};
      w_rsh   = rdata_i >> w_shift;
      wstrb_o = lane_mask(sew_i, w_off);

      case (sew_i)
         SEW_E8: begin
            wdata_o = {24'h0, sdata_i[7:0]} << w_shift;
            relem_o = {24'h0, w_rsh[7:0]};
         end
         SEW_E16: begin
            wdata_o = {16'h0, sdata_i[15:0]} << w_shift;
            relem_o = {16'h0, w_rsh[15:0]};
         end
         default: begin
            wdata_o = sdata_i;
            relem_o = rdata_i;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/vec_strided_lsu.sv
`default_nettype none
// ============================================================================
// Module   : vec_strided_lsu
// Purpose  : Vector strided load/store engine (vlse.v / vsse.v). Walks vl
//            elements from base with a signed byte stride, issuing one word
//            access per element on a valid/ready memory port and moving
//            elements to/from the vector register file.
//            Optional: VEC_LSU_MISALIGN_TRAP_EN aborts the command with err
//            on a misaligned element instead of clearing the offset bits.
// Revision : 1.0 - initial release
// ============================================================================
module vec_strided_lsu
   import vec_lsu_pkg::*;
#(
   parameter int VL_W = 6
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_store,
   input  logic [31:0]     cmd_base,
   input  logic [31:0]     cmd_stride,
   input  logic [VL_W-1:0] cmd_vl,
   input  logic [1:0]      cmd_sew,
   output logic            done,
   output logic            err,
   output logic            mem_valid,
   input  logic            mem_ready,
   output logic [31:0]     mem_addr,
   output logic [31:0]     mem_wdata,
   output logic [3:0]      mem_wstrb,
   input  logic [31:0]     mem_rdata,
   output logic            elem_we,
   output logic [VL_W-1:0] elem_idx,
   output logic [31:0]     elem_wdata,
   input  logic [31:0]     elem_rdata
);

   localparam logic [VL_W-1:0] C_ONE = VL_W'(1);

   state_e          state_q, state_d;
   logic [31:0]     ea_q, ea_d;
   logic [31:0]     stride_q, stride_d;
   logic [VL_W-1:0] vl_q, vl_d;
   logic [VL_W-1:0] idx_q, idx_d;
   logic [1:0]      sew_q, sew_d;
   logic            store_q, store_d;
   logic            alive_q;

   logic [3:0]      w_wstrb;
   logic [31:0]     w_wdata;
   logic [31:0]     w_relem;
   logic            w_misalign;
   logic            w_trap;
   logic            w_last;

   vec_lane_align u_align (
      .sew_i      (sew_q),
      .off_i      (ea_q[1:0]),
      .sdata_i    (elem_rdata),
      .rdata_i    (mem_rdata),
      .wstrb_o    (w_wstrb),
      .wdata_o    (w_wdata),
      .relem_o    (w_relem),
      .misalign_o (w_misalign)
   );

   assign elem_idx = idx_q;
   assign w_last   = (idx_q == (vl_q - C_ONE));

`ifdef VEC_LSU_MISALIGN_TRAP_EN
   logic err_q;

   assign w_trap = w_misalign;
   assign err    = (state_q == FIN) && err_q;

   // Remember a trapped element so err can accompany the done pulse
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         err_q <= 1'b0;
      end else if ((state_q == ISSUE) && w_trap) begin
         err_q <= 1'b1;
      end else if (state_q == IDLE) begin
         err_q <= 1'b0;
      end
   end
`else
   logic w_unused_misalign;

   assign w_trap            = 1'b0;
   assign err               = 1'b0;
   assign w_unused_misalign = w_misalign;
`endif

   // State, command latches and address/index accumulators
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         ea_q     <= '0;
         stride_q <= '0;
         vl_q     <= '0;
         idx_q    <= '0;
         sew_q    <= '0;
         store_q  <= 1'b0;
         alive_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ea_q     <= ea_d;
         stride_q <= stride_d;
         vl_q     <= vl_d;
         idx_q    <= idx_d;
         sew_q    <= sew_d;
         store_q  <= store_d;
         alive_q  <= 1'b1;
      end
   end

   // Next-state logic and all port outputs; outputs idle at zero
   always_comb begin
      state_d    = state_q;
      ea_d       = ea_q;
      stride_d   = stride_q;
      vl_d       = vl_q;
      idx_d      = idx_q;
      sew_d      = sew_q;
      store_d    = store_q;
      cmd_ready  = 1'b0;
      done       = 1'b0;
      mem_valid  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_wstrb  = '0;
      elem_we    = 1'b0;
      elem_wdata = '0;

      case (state_q)
         IDLE: begin
            // alive_q keeps cmd_ready low until the first clock after reset
            cmd_ready = alive_q;
            if (alive_q && cmd_valid) begin
               ea_d     = cmd_base;
               stride_d = cmd_stride;
               vl_d     = cmd_vl;
               sew_d    = cmd_sew;
               store_d  = cmd_store;
               idx_d    = '0;
               state_d  = (cmd_vl == '0) ? FIN : ISSUE;
            end
         end

         ISSUE: begin
            if (w_trap) begin
               // Misaligned element: no access, abort after earlier elements
               state_d = FIN;
            end else begin
               mem_valid = 1'b1;
               mem_addr  = {ea_q[31:2], 2'b00};
               mem_wstrb = store_q ? w_wstrb : 4'b0000;
               mem_wdata = store_q ? w_wdata : 32'h0;
               if (mem_ready) begin
                  elem_we    = !store_q;
                  elem_wdata = store_q ? 32'h0 : w_relem;
                  if (w_last) begin
                     state_d = FIN;
                  end else begin
                     idx_d = idx_q + C_ONE;
                     ea_d  = ea_q + stride_q;
                  end
               end
            end
         end

         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
